// File: rtl/if_fetch_queue.sv
// Instruction-fetch engine with a DEPTH-entry {pc, insn} prefetch queue feeding the IF/ID
// register. Issues sequential word addresses on a single-outstanding req/ack bus.
module if_fetch_queue #(
  parameter int unsigned         PC_W         = 30,
  parameter int unsigned         INSN_W       = 32,
  parameter int unsigned         DEPTH        = 4,
  parameter logic [PC_W-1:0]     RESET_VECTOR = '0,
  parameter logic [INSN_W-1:0]   NOP_INSN     = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   bus_req,
  output logic [PC_W-1:0]        bus_addr,
  input  logic                   bus_ack,
  input  logic [INSN_W-1:0]      bus_rdata,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [PC_W-1:0]        new_pc,
  input  logic                   br_taken,
  input  logic [PC_W-1:0]        br_addr,
  output logic [PC_W-1:0]        if_pc,
  output logic [INSN_W-1:0]      if_insn,
  output logic                   if_en,
  output logic [$clog2(DEPTH):0] q_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] Full = CW'(DEPTH);

  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic [INSN_W-1:0] insn_mem [DEPTH];

  logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic              req_q, req_d;
  logic [PC_W-1:0]   addr_q, addr_d;
  logic              discard_q, discard_d;
  logic [PC_W-1:0]   if_pc_q, if_pc_d;
  logic [INSN_W-1:0] if_insn_q, if_insn_d;
  logic              if_en_q, if_en_d;

  logic              redirect, ack, push, pop, issue;
  logic [PC_W-1:0]   target;

  always_comb begin
    redirect = flush | br_taken;
    target   = flush ? new_pc : br_addr;
    ack      = req_q & bus_ack;
    push     = ack & ~discard_q & ~redirect;
    pop      = ~redirect & ~stall & (count_q != '0);
  end

  // Queue bookkeeping and fetch address generation.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    discard_d  = discard_q;
    if (redirect) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      fetch_pc_d = target;
      // A request still in flight must complete before the target can be fetched.
      discard_d  = req_q & ~ack;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + AW'(1);
        fetch_pc_d = addr_q + PC_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (ack) discard_d = 1'b0;
    end
  end

  // Issue only when the slot for the returning word is guaranteed.
  always_comb begin
    issue  = (~req_q | ack) & ~discard_q & ~redirect & (count_d < Full);
    req_d  = issue | (req_q & ~ack);
    addr_d = issue ? fetch_pc_d : addr_q;
  end

  always_comb begin
    if_pc_d   = if_pc_q;
    if_insn_d = if_insn_q;
    if_en_d   = if_en_q;
    if (flush) begin
      if_pc_d   = new_pc;
      if_insn_d = NOP_INSN;
      if_en_d   = 1'b0;
    end else if (!stall) begin
      if (br_taken) begin
        if_pc_d   = br_addr;
        if_insn_d = NOP_INSN;
        if_en_d   = 1'b0;
      end else if (pop) begin
        if_pc_d   = pc_mem[rd_ptr_q];
        if_insn_d = insn_mem[rd_ptr_q];
        if_en_d   = 1'b1;
      end else begin
        if_insn_d = NOP_INSN;
        if_en_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      fetch_pc_q <= RESET_VECTOR;
      req_q      <= 1'b0;
      addr_q     <= RESET_VECTOR;
      discard_q  <= 1'b0;
      if_pc_q    <= RESET_VECTOR;
      if_insn_q  <= NOP_INSN;
      if_en_q    <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      fetch_pc_q <= fetch_pc_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      discard_q  <= discard_d;
      if_pc_q    <= if_pc_d;
      if_insn_q  <= if_insn_d;
      if_en_q    <= if_en_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= addr_q;
      insn_mem[wr_ptr_q] <= bus_rdata;
    end
  end

  assign bus_req  = req_q;
  assign bus_addr = addr_q;
  assign if_pc    = if_pc_q;
  assign if_insn  = if_insn_q;
  assign if_en    = if_en_q;
  assign q_count  = count_q;

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage that replaces the single IF/ID register with a fetch engine and a DEPTH-entry prefetch queue. It generates sequential fetch addresses and issues them on a single-outstanding req/ack instruction bus. Returned words are buffered as {pc, insn} pairs, and the IF/ID register (if_pc/if_insn/if_en) is driven from the queue head. It sits between the instruction bus and the decode stage and honours decode stall, pipeline flush and branch redirect.

## Interface
- PC_W, 30, word-address width of all PC/address signals
- INSN_W, 32, instruction width
- DEPTH, 4, prefetch queue entries; power of two, ≥2
- RESET_VECTOR, 0, PC after reset (PC_W bits)
- NOP_INSN, 0, instruction value driven on bubbles (INSN_W bits)

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- bus_req  out  1  fetch request; registered
- bus_addr  out  PC_W  fetch word address; registered, stable while bus_req high until ack
- bus_ack  in  1  request complete; bus_rdata valid in same cycle; ignored when bus_req low
- bus_rdata  in  INSN_W  fetched instruction
- stall  in  1  decode stall; holds the IF/ID register
- flush  in  1  pipeline flush pulse; redirects fetch to new_pc
- new_pc  in  PC_W  flush target
- br_taken  in  1  branch redirect pulse; redirects fetch to br_addr
- br_addr  in  PC_W  branch target
- if_pc  out  PC_W  IF/ID program counter
- if_insn  out  INSN_W  IF/ID instruction
- if_en  out  1  IF/ID valid
- q_count  out  $clog2(DEPTH)+1  current queue occupancy

## Operation
- Reset values:
  - if_pc=RESET_VECTOR, if_insn=NOP_INSN, if_en=0
  - bus_req=0, bus_addr=RESET_VECTOR, q_count=0
  - internal fetch_pc=RESET_VECTOR, discard=0
- Redirect: flush has priority over br_taken.
  - Target is new_pc for flush, br_addr for br_taken.
  - Taken regardless of stall.
  - At the redirect edge: queue emptied (q_count=0) and fetch_pc set to the target.
  - If a request is outstanding and not acked in the redirect cycle: discard set; bus_req/bus_addr held until ack; acked data dropped; discard cleared.
  - Ack in the redirect cycle: data dropped, discard not set.
- Request issue:
  - Issued at an edge when no request remains outstanding after that edge, discard=0, no redirect in that cycle, and post-edge q_count < DEPTH.
  - The slot is reserved, so a push never overflows.
  - bus_addr=fetch_pc at issue.
- Ack with discard=0 and no redirect:
  - Push {bus_addr, bus_rdata} to the queue tail.
  - fetch_pc = bus_addr+1, modulo 2^PC_W (wraps from all-ones to 0).
- IF/ID register update, priority order:
  - flush: if_pc=new_pc, if_insn=NOP_INSN, if_en=0, even if stall=1.
  - else stall=1: hold.
  - else br_taken: bubble (if_insn=NOP_INSN, if_en=0); if_pc=br_addr.
  - else queue non-empty: pop head into if_pc/if_insn, if_en=1.
  - else bubble: if_en=0, if_insn=NOP_INSN, if_pc unchanged.
- Queue:
  - Push and pop in the same cycle are both allowed, including at full or with one entry.
  - No push/pop-through bypass.

## Timing
- First bus_req rises at the first edge after reset deassertion, with bus_addr=RESET_VECTOR.
- Ack in cycle N (edge E): entry visible at E, q_count+1. Earliest if_en=1 for it at E+1.
- Back-to-back: after ack at E, the next request may rise at E itself with bus_addr+1. Zero-wait bus gives one word per cycle.
- After a redirect at edge R:
  - No outstanding request: bus_req with the target at R+1.
  - Outstanding request: bus_req with the target at the edge after the stale ack.
- Redirect asserted while reset is low is ignored. Reset mid-request drops bus_req immediately (async).

## Test plan
- Reset release, bus_ack tied 1, stall=0 → bus_addr 0,1,2,…; if_en=1 from edge 3 with if_pc 0,1,2 consecutive, one per cycle.
- stall=1 for 10 cycles, DEPTH=4 → q_count reaches 4, bus_req stays low, IF/ID held. Release stall → four pops then steady streaming, no lost/duplicated PC.
- Bus latency 3 cycles, br_taken to 0x100 one cycle after issue → stale word dropped, q_count=0. Next bus_addr=0x100, then if_pc=0x100 with if_en=1.
- flush with stall=1 and ack in the same cycle → if_en=0 and if_insn=NOP_INSN next edge. Acked word not queued. Next fetch at new_pc.
- fetch_pc = 2^PC_W−1 → next bus_addr=0.
- flush and br_taken simultaneous → target=new_pc, br_addr ignored.
